// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
//
// Owns the single register-file write port. After reset it can sweep WrAdr
// through registers 1..31 writing zero (register-file clear). After that it
// round-robin arbitrates between two writeback requesters, ALU (port 0) and
// load/memory (port 1). The winner is registered onto the write port, and
// writes to $zero are suppressed.
//
// Ports:
//   Clk, Reset_n            rising-edge clock, asynchronous active-low reset
//   Stall                   freeze: no grant this cycle (ignored during INIT)
//   Req0_Valid/Adr/Data     ALU writeback request
//   Req0_Ready              combinational grant to port 0
//   Req1_Valid/Adr/Data     load writeback request
//   Req1_Ready              combinational grant to port 1
//   WrEn, WrAdr, WrData     registered write port (WrAdr feeds the decoder)
//   InitDone                high once the clear sweep has finished (RUN)
//   Collision               one-cycle pulse: both valid to the same nonzero reg
// -----------------------------------------------------------------------------
module rf_write_arbiter #(
  parameter int unsigned DATA_W         = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Stall,
  input  logic              Req0_Valid,
  input  logic [4:0]        Req0_Adr,
  input  logic [DATA_W-1:0] Req0_Data,
  output logic              Req0_Ready,
  input  logic              Req1_Valid,
  input  logic [4:0]        Req1_Adr,
  input  logic [DATA_W-1:0] Req1_Data,
  output logic              Req1_Ready,
  output logic              WrEn,
  output logic [4:0]        WrAdr,
  output logic [DATA_W-1:0] WrData,
  output logic              InitDone,
  output logic              Collision
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

  state_e            state_q, state_d;
  logic [4:0]        init_cnt_q, init_cnt_d;
  logic              ptr_q, ptr_d;          // 0 = port 0 favoured on a tie
  logic              wr_en_q, wr_en_d;
  logic [4:0]        wr_adr_q, wr_adr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              collision_q, collision_d;
  logic              grant0, grant1;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    ptr_d       = ptr_q;
    wr_en_d     = 1'b0;
    wr_adr_d    = wr_adr_q;   // address/data hold when nothing is granted
    wr_data_d   = wr_data_q;
    collision_d = 1'b0;
    grant0      = 1'b0;
    grant1      = 1'b0;

    case (state_q)
      ST_INIT: begin
        // Clear sweep: one zero write per edge; requesters are never granted.
        wr_en_d    = 1'b1;
        wr_adr_d   = init_cnt_q;
        wr_data_d  = '0;
        init_cnt_d = init_cnt_q + 5'd1;
        if (init_cnt_q == 5'd31) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!Stall) begin
          if (Req0_Valid && Req1_Valid) begin
            grant0      = ~ptr_q;
            grant1      = ptr_q;
            // Same target from both sides: the loser retries next cycle, so
            // the later write lands last in the register file.
            collision_d = (Req0_Adr == Req1_Adr) && (Req0_Adr != 5'd0);
          end else begin
            grant0 = Req0_Valid;
            grant1 = Req1_Valid;
          end
        end

        // A granted $zero target is consumed but never written.
        if (grant0) begin
          ptr_d     = 1'b1;
          wr_adr_d  = Req0_Adr;
          wr_data_d = Req0_Data;
          wr_en_d   = (Req0_Adr != 5'd0);
        end else if (grant1) begin
          ptr_d     = 1'b0;
          wr_adr_d  = Req1_Adr;
          wr_data_d = Req1_Data;
          wr_en_d   = (Req1_Adr != 5'd0);
        end
      end

      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values computed before the edge, independent of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= RESET_STATE;
      init_cnt_q  <= 5'd1;
      ptr_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_adr_q    <= 5'd0;
      wr_data_q   <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      ptr_q       <= ptr_d;
      wr_en_q     <= wr_en_d;
      wr_adr_q    <= wr_adr_d;
      wr_data_q   <= wr_data_d;
      collision_q <= collision_d;
    end
  end

  assign Req0_Ready = grant0;
  assign Req1_Ready = grant1;
  assign WrEn       = wr_en_q;
  assign WrAdr      = wr_adr_q;
  assign WrData     = wr_data_q;
  assign InitDone   = (state_q == ST_RUN);
  assign Collision  = collision_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
//
// Directed stimulus for rf_write_arbiter. Every write the register file should
// see is pushed into an expected-write queue as the stimulus is issued; a
// separate monitor pops and compares on every cycle the DUT asserts WrEn.
// Grants, Collision, InitDone and suppressed writes are checked inline.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;

  localparam int DATA_W = 32;

  typedef struct {
    logic [4:0]        adr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              Clk;
  logic              Reset_n;
  logic              Stall;
  logic              Req0_Valid;
  logic [4:0]        Req0_Adr;
  logic [DATA_W-1:0] Req0_Data;
  logic              Req0_Ready;
  logic              Req1_Valid;
  logic [4:0]        Req1_Adr;
  logic [DATA_W-1:0] Req1_Data;
  logic              Req1_Ready;
  logic              WrEn;
  logic [4:0]        WrAdr;
  logic [DATA_W-1:0] WrData;
  logic              InitDone;
  logic              Collision;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  rf_write_arbiter #(
    .DATA_W        (DATA_W),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Stall     (Stall),
    .Req0_Valid(Req0_Valid),
    .Req0_Adr  (Req0_Adr),
    .Req0_Data (Req0_Data),
    .Req0_Ready(Req0_Ready),
    .Req1_Valid(Req1_Valid),
    .Req1_Adr  (Req1_Adr),
    .Req1_Data (Req1_Data),
    .Req1_Ready(Req1_Ready),
    .WrEn      (WrEn),
    .WrAdr     (WrAdr),
    .WrData    (WrData),
    .InitDone  (InitDone),
    .Collision (Collision)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [4:0] adr, input logic [DATA_W-1:0] data);
    wr_t e;
    e.adr  = adr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Stall      = 1'b0;
    Req0_Valid = 1'b0;
    Req0_Adr   = 5'd0;
    Req0_Data  = '0;
    Req1_Valid = 1'b0;
    Req1_Adr   = 5'd0;
    Req1_Data  = '0;
  endtask

  // Runs the 31-edge clear sweep from reset release; clears must already be queued.
  task automatic init_sweep(input string tag);
    for (int k = 1; k <= 31; k++) begin
      check({tag, "_rdy0"}, Req0_Ready, 1'b0);
      check({tag, "_rdy1"}, Req1_Ready, 1'b0);
      tick();
      check({tag, "_adr"}, WrAdr, k);
      check({tag, "_done"}, InitDone, (k == 31));
    end
  endtask

  // Monitor: every asserted write must match the next expected write.
  always @(negedge Clk) begin
    if (Reset_n === 1'b1 && WrEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got adr=%0d data=%h expected no write (t=%0t)",
                 WrAdr, WrData, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("mon_wr_adr", WrAdr, e.adr);
        check("mon_wr_data", WrData, e.data);
      end
    end
  end

  initial begin
    Reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge Clk);
    #1;

    // Reset values
    check("rst_wren", WrEn, 1'b0);
    check("rst_wradr", WrAdr, 5'd0);
    check("rst_wrdata", WrData, 32'h0);
    check("rst_coll", Collision, 1'b0);
    check("rst_done", InitDone, 1'b0);

    // Clear sweep, with requests applied during the first 20 edges
    for (int k = 1; k <= 31; k++) push_wr(5'(k), '0);
    Req0_Valid = 1'b1; Req0_Adr = 5'd9;  Req0_Data = 32'h99;
    Req1_Valid = 1'b1; Req1_Adr = 5'd10; Req1_Data = 32'hAA;
    Reset_n = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      if (k == 21) idle_inputs();
      check("init_rdy0", Req0_Ready, 1'b0);
      check("init_rdy1", Req1_Ready, 1'b0);
      tick();
      check("init_adr", WrAdr, k);
      check("init_done", InitDone, (k == 31));
    end

    // Port 0 only (Ptr 0 -> 1)
    Req0_Valid = 1'b1; Req0_Adr = 5'd8; Req0_Data = 32'hDEADBEEF;
    #1;
    check("p0_rdy0", Req0_Ready, 1'b1);
    check("p0_rdy1", Req1_Ready, 1'b0);
    push_wr(5'd8, 32'hDEADBEEF);
    tick();
    Req0_Valid = 1'b0;
    check("p0_wren", WrEn, 1'b1);
    check("p0_wradr", WrAdr, 5'd8);

    // Port 1 to $zero: consumed, no write, address/data still update (Ptr -> 0)
    Req1_Valid = 1'b1; Req1_Adr = 5'd0; Req1_Data = 32'h1234;
    #1;
    check("z_rdy1", Req1_Ready, 1'b1);
    check("z_rdy0", Req0_Ready, 1'b0);
    tick();
    Req1_Valid = 1'b0;
    check("z_wren", WrEn, 1'b0);
    check("z_wradr", WrAdr, 5'd0);
    check("z_wrdata", WrData, 32'h1234);

    // Both valid for 4 cycles: grants 0,1,0,1
    Req0_Valid = 1'b1; Req0_Adr = 5'd3; Req0_Data = 32'hA0A0A0A0;
    Req1_Valid = 1'b1; Req1_Adr = 5'd4; Req1_Data = 32'hB1B1B1B1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_rdy0", Req0_Ready, (i % 2 == 0));
      check("rr_rdy1", Req1_Ready, (i % 2 == 1));
      if (i % 2 == 0) push_wr(5'd3, 32'hA0A0A0A0);
      else            push_wr(5'd4, 32'hB1B1B1B1);
      tick();
    end
    idle_inputs();

    // Collision on register 17: port 0 (Ptr 0) first, then port 1
    Req0_Valid = 1'b1; Req0_Adr = 5'd17; Req0_Data = 32'hC0C0C0C0;
    Req1_Valid = 1'b1; Req1_Adr = 5'd17; Req1_Data = 32'hC1C1C1C1;
    #1;
    check("col_rdy0", Req0_Ready, 1'b1);
    push_wr(5'd17, 32'hC0C0C0C0);
    tick();
    check("col_pulse", Collision, 1'b1);
    Req0_Valid = 1'b0;
    #1;
    check("col_rdy1", Req1_Ready, 1'b1);
    push_wr(5'd17, 32'hC1C1C1C1);
    tick();
    check("col_end", Collision, 1'b0);
    Req1_Valid = 1'b0;

    // Stall with both valid: no grant, no write, Ptr stays 0
    Stall = 1'b1;
    Req0_Valid = 1'b1; Req0_Adr = 5'd5; Req0_Data = 32'h55;
    Req1_Valid = 1'b1; Req1_Adr = 5'd6; Req1_Data = 32'h66;
    #1;
    check("stall_rdy0", Req0_Ready, 1'b0);
    check("stall_rdy1", Req1_Ready, 1'b0);
    tick();
    check("stall_wren", WrEn, 1'b0);
    Stall = 1'b0;
    #1;
    check("unstall_rdy0", Req0_Ready, 1'b1);
    push_wr(5'd5, 32'h55);
    tick();
    idle_inputs();

    // Reset mid-stream with a grant in flight (Ptr is 1 here)
    @(negedge Clk);
    #1;
    Req0_Valid = 1'b1; Req0_Adr = 5'd12; Req0_Data = 32'h12;
    Req1_Valid = 1'b1; Req1_Adr = 5'd13; Req1_Data = 32'h13;
    #1;
    check("pre_rst_rdy1", Req1_Ready, 1'b1);
    Reset_n = 1'b0;
    #1;
    check("mid_rst_wren", WrEn, 1'b0);
    check("mid_rst_wradr", WrAdr, 5'd0);
    check("mid_rst_wrdata", WrData, 32'h0);
    check("mid_rst_done", InitDone, 1'b0);
    check("mid_rst_rdy1", Req1_Ready, 1'b0);
    idle_inputs();
    tick();
    for (int k = 1; k <= 31; k++) push_wr(5'(k), '0);
    Reset_n = 1'b1;
    init_sweep("reinit");

    // Ptr was cleared by reset: port 0 wins the tie
    Req0_Valid = 1'b1; Req0_Adr = 5'd20; Req0_Data = 32'h20;
    Req1_Valid = 1'b1; Req1_Adr = 5'd21; Req1_Data = 32'h21;
    #1;
    check("post_rst_rdy0", Req0_Ready, 1'b1);
    check("post_rst_rdy1", Req1_Ready, 1'b0);
    push_wr(5'd20, 32'h20);
    tick();
    idle_inputs();
    repeat (2) tick();

    check("exp_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the single register-file write port; its registered WrAdr output drives the 5-to-32 write-select decoder directly.
- After reset it walks WrAdr through registers 1..31, writing zero to each (register-file clear).
- In normal operation it round-robin arbitrates between two writeback requesters: ALU (port 0) and load/memory (port 1).
- Registers the winner onto the write port and suppresses all writes to $zero.

Parameters:
- DATA_W, 32, width of write data.
- CLEAR_ON_RESET, 1, 1 = run the INIT clear sweep after reset; 0 = go straight to RUN.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Stall  in  1  1 = grant nothing this cycle (pipeline freeze); does not pause INIT.
- Req0_Valid  in  1  ALU writeback request.
- Req0_Adr  in  5  ALU destination register.
- Req0_Data  in  DATA_W  ALU result.
- Req0_Ready  out  1  combinational grant to port 0.
- Req1_Valid  in  1  load writeback request.
- Req1_Adr  in  5  load destination register.
- Req1_Data  in  DATA_W  load data.
- Req1_Ready  out  1  combinational grant to port 1.
- WrEn  out  1  registered register-file write enable.
- WrAdr  out  5  registered write address, feeds the decoder.
- WrData  out  DATA_W  registered write data.
- InitDone  out  1  1 when state = RUN.
- Collision  out  1  registered pulse: both valid, same nonzero Adr in the same cycle.

Behaviour:
- Reset (async, Reset_n=0):
  - WrEn=0, WrAdr=0, WrData=0, Collision=0.
  - Priority pointer Ptr=0 (port 0 favoured).
  - InitCnt=1.
  - State=INIT if CLEAR_ON_RESET else RUN.
- State INIT:
  - Req0_Ready=Req1_Ready=0; InitDone=0; Stall ignored.
  - Each edge registers WrEn=1, WrAdr=InitCnt, WrData=0, then InitCnt++.
  - The edge that registers WrAdr=31 also moves State to RUN.
  - Net effect: 31 clear writes on edges 1..31 after reset release; InitDone=1 from edge 31.
- State RUN, grant logic (combinational, in the same cycle as Valid):
  - Stall=1: no grant.
  - Exactly one Valid: grant that port.
  - Both Valid: grant port Ptr.
  - ReqN_Ready=1 only for the granted port. Transfer occurs when Valid & Ready.
- State RUN, grant effects:
  - A grant to port i sets Ptr=1-i on the same edge. Ptr is unchanged when there is no grant.
  - The granted port's Adr and Data are registered onto WrAdr/WrData at the next edge (latency 1).
  - WrEn=1 only if the granted Adr != 0.
  - A granted Adr=0 is consumed (Ready=1) but produces WrEn=0; WrAdr/WrData still update.
  - No grant: WrEn=0 next cycle; WrAdr/WrData hold their previous values.
- Collision:
  - Registered 1 for one cycle when both Valid, Req0_Adr==Req1_Adr!=0, and Stall=0.
  - Arbitration is unaffected; the loser retries next cycle, so the later write wins in the register file.
- Requesters must hold Valid/Adr/Data stable until Ready. The block does not buffer requests.
- Reset asserted mid-INIT or mid-RUN:
  - All outputs go to reset values immediately, Ptr is cleared, and INIT restarts from register 1.
  - Any in-flight grant is lost.
- No state other than INIT/RUN. RUN→INIT happens only via reset.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, all Valid=0 → WrEn=1 for exactly 31 edges with WrAdr=1,2,…,31 and WrData=0. InitDone rises with WrAdr=31. Ready stays 0 throughout, even with Valid=1 applied during INIT.
- RUN, Req0 only: Adr=5'd8, Data=32'hDEADBEEF → Req0_Ready=1 in the same cycle. Next cycle WrEn=1, WrAdr=8, WrData=32'hDEADBEEF.
- RUN, both Valid held 4 cycles (Req0 Adr=3, Req1 Adr=4), Ptr=0 → grants alternate 0,1,0,1. WrAdr sequence is 3,4,3,4.
- RUN, Req1 Adr=0, Data=32'h1234 → Req1_Ready=1, next cycle WrEn=0.
- RUN, both Valid with Adr=5'd17 → Collision=1 for one cycle. Two successive writes to 17, port Ptr first.
- Stall=1 with both Valid → both Ready=0 and WrEn=0. Reset_n pulsed low mid-stream → outputs zero immediately and the INIT sweep restarts at WrAdr=1.
